// File: rtl/cpu_defs.sv
// Shared definitions for the DIV/DIVU sequencer.
// Holds the operand width, iteration counter width, the sequencer state
// encoding, the divide-by-zero quotient constant and a magnitude helper.
package cpu_defs;

    localparam int unsigned WIDTH = 32;
    // Counter must hold 0..WIDTH, so at least clog2(WIDTH+1) bits.
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [WIDTH-1:0] DIV0_LO = '1;

    // Absolute value when the operand is treated as signed, raw otherwise.
    // 2^(WIDTH-1) maps onto itself, which the unsigned core handles correctly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divider handshake bundle.
//   master : pipeline side (drives start/signed_div/opa/opb/flush)
//   slave  : divider side (drives stall/busy/hilo_write/hi/lo)
interface div_sequencer_if;

    logic                        start;
    logic                        signed_div;
    logic [cpu_defs::WIDTH-1:0]  opa;
    logic [cpu_defs::WIDTH-1:0]  opb;
    logic                        flush;
    logic                        stall;
    logic                        busy;
    logic                        hilo_write;
    logic [cpu_defs::WIDTH-1:0]  hi;
    logic [cpu_defs::WIDTH-1:0]  lo;

    modport master (
        output start, signed_div, opa, opb, flush,
        input  stall, busy, hilo_write, hi, lo
    );

    modport slave (
        input  start, signed_div, opa, opb, flush,
        output stall, busy, hilo_write, hi, lo
    );

endinterface

// File: rtl/clz32.sv
// Combinational leading-zero count of a 32-bit value.
// Only present when DIV_EARLY_TERM_EN is defined.
//   value : input word
//   count : number of leading zeros, 0..32 (32 for a zero word)
`ifdef DIV_EARLY_TERM_EN
module clz32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scan upward so the highest set bit writes last.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule
`endif

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divide that stalls the
// front of the pipeline while running and writes HI/LO with a one-cycle strobe.
// Optional macro DIV_EARLY_TERM_EN skips the dividend's leading zeros.
//   clk, rst           : clock, synchronous active-high reset
//   bus.start          : E-stage DIV/DIVU valid (sampled only in IDLE)
//   bus.signed_div     : 1 = DIV, 0 = DIVU
//   bus.opa / bus.opb  : dividend / divisor
//   bus.flush          : E-stage flush, cancels any operation
//   bus.stall          : freeze F/D/E
//   bus.busy           : state is not IDLE
//   bus.hilo_write     : one-cycle HI/LO write strobe
//   bus.hi / bus.lo    : remainder / quotient
module div_sequencer
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            rst,
    div_sequencer_if.slave  bus
);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  dvsr;
    logic              qneg;
    logic              rneg;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    logic              a_neg_c;
    logic              b_neg_c;
    logic [WIDTH-1:0]  a_mag_c;
    logic [WIDTH-1:0]  b_mag_c;
    logic [WIDTH-1:0]  quo_init_c;
    logic [CNT_W-1:0]  cnt_init_c;
    logic              a_zero_c;
    logic [WIDTH:0]    rem_sh_c;
    logic [WIDTH:0]    diff_c;
    logic [WIDTH-1:0]  rem_nxt_c;
    logic [WIDTH-1:0]  quo_nxt_c;

    // Operand conditioning for the accept cycle.
    always_comb begin
        a_neg_c = bus.signed_div & bus.opa[WIDTH-1];
        b_neg_c = bus.signed_div & bus.opb[WIDTH-1];
        a_mag_c = mag(bus.opa, bus.signed_div);
        b_mag_c = mag(bus.opb, bus.signed_div);
    end

`ifdef DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] lz_c;

    clz32 u_clz (
        .value (a_mag_c),
        .count (lz_c)
    );

    // Pre-shifting past the leading zeros and starting the counter at z
    // yields WIDTH - z RUN cycles with an identical result.
    always_comb begin
        quo_init_c = a_mag_c << lz_c;
        cnt_init_c = lz_c;
        a_zero_c   = (lz_c == CNT_W'(WIDTH));
    end
`else
    always_comb begin
        quo_init_c = a_mag_c;
        cnt_init_c = '0;
        a_zero_c   = 1'b0;
    end
`endif

    // One restoring step: shift {r, q} left, trial-subtract the divisor.
    // r < divisor always, so a shifted r with its top bit set always subtracts.
    always_comb begin
        rem_sh_c  = {rem, quo[WIDTH-1]};
        diff_c    = rem_sh_c - {1'b0, dvsr};
        quo_nxt_c = {quo[WIDTH-2:0], ~diff_c[WIDTH]};
        rem_nxt_c = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    end

    // Handshake outputs; stall and strobe are gated off while in reset.
    always_comb begin
        bus.stall      = ~rst & (((state == IDLE) & bus.start & ~bus.flush) |
                                 (state == RUN));
        bus.busy       = (state != IDLE);
        bus.hilo_write = ~rst & (state == DONE) & ~bus.flush;
        bus.hi         = hi_q;
        bus.lo         = lo_q;
    end

    // Sequencer state and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvsr <= b_mag_c;
                        rem  <= '0;
                        quo  <= quo_init_c;
                        cnt  <= cnt_init_c;
                        qneg <= a_neg_c ^ b_neg_c;
                        rneg <= a_neg_c;
                        if (bus.opb == '0) begin
                            hi_q  <= bus.opa;
                            lo_q  <= DIV0_LO;
                            state <= DONE;
                        end else if (a_zero_c) begin
                            hi_q  <= '0;
                            lo_q  <= '0;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt_c;
                    quo <= quo_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        lo_q  <= qneg ? -quo_nxt_c : quo_nxt_c;
                        hi_q  <= rneg ? -rem_nxt_c : rem_nxt_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
